// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: two-requester AXI4 read-channel arbiter.
// m0 (instruction fetch) and m1 (load/store) share one downstream AXI4 read
// port. A grant is held from the address handshake until the rlast beat
// completes. Arbitration is round-robin, or fixed priority for m0 when
// FIX_PRIO is set. The write channels do not pass through this block.
module axi_rd_arbiter #(
  parameter int FIX_PRIO = 0,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input  logic              clock,
  input  logic              reset,

  // requester 0 (fetch path)
  input  logic              m0_arvalid,
  output logic              m0_arready,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [7:0]        m0_arlen,
  input  logic [1:0]        m0_arburst,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rlast,

  // requester 1 (load path)
  input  logic              m1_arvalid,
  output logic              m1_arready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [7:0]        m1_arlen,
  input  logic [1:0]        m1_arburst,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rlast,

  // downstream AXI4 read port
  output logic              s_arvalid,
  input  logic              s_arready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic [7:0]        s_arlen,
  output logic [1:0]        s_arburst,
  output logic [3:0]        s_arid,
  output logic [2:0]        s_arsize,
  input  logic              s_rvalid,
  output logic              s_rready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rlast
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t state;
  logic   owner;
  logic   last_owner;
  logic   grant_next;
  logic   in_addr;
  logic   in_data;
  logic   own_arvalid;
  logic   own_rready;

  // Winner of the IDLE-cycle arbitration; only consulted when a request is present
  always_comb begin
    grant_next = owner;
    if (m0_arvalid && m1_arvalid) begin
      grant_next = (FIX_PRIO != 0) ? 1'b0 : ~last_owner;
    end else if (m0_arvalid) begin
      grant_next = 1'b0;
    end else if (m1_arvalid) begin
      grant_next = 1'b1;
    end
  end

  // Transaction FSM: grant in IDLE, forward address in ADDR, stream beats in DATA
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (m0_arvalid || m1_arvalid) begin
            owner <= grant_next;
            state <= ADDR;
          end
        end
        ADDR: begin
          if (s_arvalid && s_arready) begin
            state <= DATA;
          end
        end
        DATA: begin
          // the beat count is not tracked; rlast alone closes the transaction
          if (s_rvalid && s_rready && s_rlast) begin
            state      <= IDLE;
            last_owner <= owner;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_addr     = (state == ADDR);
  assign in_data     = (state == DATA);
  assign own_arvalid = owner ? m1_arvalid : m0_arvalid;
  assign own_rready  = owner ? m1_rready  : m0_rready;

  // Address channel: owner's request passes through unmodified
  assign s_arvalid  = in_addr & own_arvalid;
  assign s_araddr   = owner ? m1_araddr  : m0_araddr;
  assign s_arlen    = owner ? m1_arlen   : m0_arlen;
  assign s_arburst  = owner ? m1_arburst : m0_arburst;
  assign s_arid     = {3'b000, owner};
  assign s_arsize   = 3'b010;
  assign m0_arready = in_addr & ~owner & s_arready;
  assign m1_arready = in_addr &  owner & s_arready;

  // Read data channel: only the owner sees valid/last; data and resp fan out to both
  assign s_rready  = in_data & own_rready;
  assign m0_rvalid = in_data & ~owner & s_rvalid;
  assign m1_rvalid = in_data &  owner & s_rvalid;
  assign m0_rlast  = in_data & ~owner & s_rlast;
  assign m1_rlast  = in_data &  owner & s_rlast;
  assign m0_rdata  = s_rdata;
  assign m1_rdata  = s_rdata;
  assign m0_rresp  = s_rresp;
  assign m1_rresp  = s_rresp;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: scoreboard bench for axi_rd_arbiter.
// A transaction-level model predicts each grant (who, which address) and the
// slave model queues every read beat it issues for its destination requester.
// A negedge monitor pops and compares; drivers act 1ns after the rising edge.
module tb_axi_rd_arbiter;

  logic        clock;
  logic        reset;

  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
  logic [31:0] m0_araddr, m0_rdata;
  logic [7:0]  m0_arlen;
  logic [1:0]  m0_arburst, m0_rresp;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rlast;
  logic [31:0] m1_araddr, m1_rdata;
  logic [7:0]  m1_arlen;
  logic [1:0]  m1_arburst, m1_rresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
  logic [31:0] s_araddr, s_rdata;
  logic [7:0]  s_arlen;
  logic [1:0]  s_arburst, s_rresp;
  logic [3:0]  s_arid;
  logic [2:0]  s_arsize;

  // second instance with fixed priority, fed by constant saturating traffic
  logic        f_m0_arready, f_m0_rvalid, f_m0_rlast;
  logic        f_m1_arready, f_m1_rvalid, f_m1_rlast;
  logic [31:0] f_m0_rdata, f_m1_rdata, f_s_araddr;
  logic [1:0]  f_m0_rresp, f_m1_rresp, f_s_arburst;
  logic        f_s_arvalid, f_s_rready;
  logic [7:0]  f_s_arlen;
  logic [3:0]  f_s_arid;
  logic [2:0]  f_s_arsize;

  axi_rd_arbiter #(.FIX_PRIO(0), .ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
    .m0_arlen(m0_arlen), .m0_arburst(m0_arburst), .m0_rvalid(m0_rvalid),
    .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
    .m1_arlen(m1_arlen), .m1_arburst(m1_arburst), .m1_rvalid(m1_rvalid),
    .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arburst(s_arburst), .s_arid(s_arid), .s_arsize(s_arsize), .s_rvalid(s_rvalid),
    .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast)
  );

  axi_rd_arbiter #(.FIX_PRIO(1), .ADDR_W(32), .DATA_W(32)) dut_fp (
    .clock(clock), .reset(reset),
    .m0_arvalid(1'b1), .m0_arready(f_m0_arready), .m0_araddr(32'h1000_0000),
    .m0_arlen(8'd0), .m0_arburst(2'b01), .m0_rvalid(f_m0_rvalid),
    .m0_rready(1'b1), .m0_rdata(f_m0_rdata), .m0_rresp(f_m0_rresp), .m0_rlast(f_m0_rlast),
    .m1_arvalid(1'b1), .m1_arready(f_m1_arready), .m1_araddr(32'h2000_0000),
    .m1_arlen(8'd0), .m1_arburst(2'b01), .m1_rvalid(f_m1_rvalid),
    .m1_rready(1'b1), .m1_rdata(f_m1_rdata), .m1_rresp(f_m1_rresp), .m1_rlast(f_m1_rlast),
    .s_arvalid(f_s_arvalid), .s_arready(1'b1), .s_araddr(f_s_araddr), .s_arlen(f_s_arlen),
    .s_arburst(f_s_arburst), .s_arid(f_s_arid), .s_arsize(f_s_arsize), .s_rvalid(1'b1),
    .s_rready(f_s_rready), .s_rdata(32'h5a5a_5a5a), .s_rresp(2'b00), .s_rlast(1'b1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic        id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
  } ar_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_t;

  ar_t exp_ar[$];
  r_t  exp_r0[$];
  r_t  exp_r1[$];

  int n_cmp = 0;
  int n_err = 0;
  int fp_grants = 0;

  // transaction-level model of the arbiter
  logic mdl_on    = 1'b0;
  logic mdl_idle  = 1'b1;
  logic mdl_data  = 1'b0;
  logic mdl_owner = 1'b0;
  logic mdl_last  = 1'b1;
  logic just_gr   = 1'b0;

  // monitor -> driver notifications, sampled at negedge
  logic       ar_hs0 = 1'b0, ar_hs1 = 1'b0, r_hs = 1'b0;
  logic       sl_start = 1'b0;
  logic [7:0] sl_start_len = 8'd0;
  logic       sl_start_id = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor + reference model: compare what the DUT shows, then advance the model
  always @(negedge clock) begin
    logic o_arv, o_arready, o_rvalid, o_rready, n_arready, n_rvalid, n_rlast, w;
    ar_t  e;
    r_t   rb;
    ar_hs0   = m0_arvalid && m0_arready;
    ar_hs1   = m1_arvalid && m1_arready;
    r_hs     = s_rvalid && s_rready;
    sl_start = 1'b0;
    if (reset) begin
      exp_ar.delete(); exp_r0.delete(); exp_r1.delete();
      mdl_on = 1'b1; mdl_idle = 1'b1; mdl_data = 1'b0;
      mdl_owner = 1'b0; mdl_last = 1'b1; just_gr = 1'b0;
      ar_hs0 = 1'b0; ar_hs1 = 1'b0; r_hs = 1'b0;
    end else if (mdl_on) begin
      o_arv     = mdl_owner ? m1_arvalid : m0_arvalid;
      o_arready = mdl_owner ? m1_arready : m0_arready;
      o_rvalid  = mdl_owner ? m1_rvalid  : m0_rvalid;
      o_rready  = mdl_owner ? m1_rready  : m0_rready;
      n_arready = mdl_owner ? m0_arready : m1_arready;
      n_rvalid  = mdl_owner ? m0_rvalid  : m1_rvalid;
      n_rlast   = mdl_owner ? m0_rlast   : m1_rlast;
      if (mdl_idle) begin
        chk("idle_quiet", 64'({s_arvalid, s_rready, m0_arready, m1_arready,
                               m0_rvalid, m1_rvalid, m0_rlast, m1_rlast}), 64'd0);
      end else begin
        chk("nonowner_quiet", 64'({n_arready, n_rvalid, n_rlast}), 64'd0);
        if (just_gr)
          chk("grant_latency", 64'({s_arvalid, s_arid}), 64'({1'b1, 3'b000, mdl_owner}));
        if (!mdl_data)
          chk("ar_mirror", 64'({s_arvalid, o_arready, s_rready, o_rvalid}),
              64'({o_arv, s_arready, 2'b00}));
        else
          chk("r_mirror", 64'({s_arvalid, s_rready, o_rvalid, o_arready}),
              64'({1'b0, o_rready, s_rvalid, 1'b0}));
      end

      if (s_arvalid && s_arready) begin
        if (exp_ar.size() == 0) begin
          chk("ar_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_ar.pop_front();
          chk("ar_fields", 64'({s_arid, s_araddr, s_arlen, s_arburst, s_arsize}),
              64'({3'b000, e.id, e.addr, e.len, e.burst, 3'b010}));
          sl_start = 1'b1; sl_start_len = e.len; sl_start_id = e.id;
        end
      end
      if (m0_rvalid && m0_rready) begin
        if (exp_r0.size() == 0) chk("m0_beat_unexpected", 64'd1, 64'd0);
        else begin
          rb = exp_r0.pop_front();
          chk("m0_beat", 64'({m0_rdata, m0_rresp, m0_rlast}), 64'(rb));
        end
      end
      if (m1_rvalid && m1_rready) begin
        if (exp_r1.size() == 0) chk("m1_beat_unexpected", 64'd1, 64'd0);
        else begin
          rb = exp_r1.pop_front();
          chk("m1_beat", 64'({m1_rdata, m1_rresp, m1_rlast}), 64'(rb));
        end
      end

      // model advance: a decision is made only at the idle point
      just_gr = 1'b0;
      if (mdl_idle) begin
        if (m0_arvalid || m1_arvalid) begin
          w = (m0_arvalid && m1_arvalid) ? ~mdl_last : m1_arvalid;
          e.id    = w;
          e.addr  = w ? m1_araddr  : m0_araddr;
          e.len   = w ? m1_arlen   : m0_arlen;
          e.burst = w ? m1_arburst : m0_arburst;
          exp_ar.push_back(e);
          mdl_owner = w; mdl_idle = 1'b0; just_gr = 1'b1;
        end
      end else if (!mdl_data) begin
        if (o_arv && s_arready) mdl_data = 1'b1;
      end else if (s_rvalid && s_rlast && o_rready) begin
        mdl_last = mdl_owner; mdl_idle = 1'b1; mdl_data = 1'b0;
      end
    end
  end

  // Fixed-priority instance: every address handshake must belong to m0
  always @(negedge clock) begin
    if (!reset && mdl_on && f_s_arvalid) begin
      chk("fp_grant", 64'({f_s_arid, f_m1_arready, f_m1_rvalid}), 64'd0);
      fp_grants++;
    end
  end

  // driver state
  logic       en0, en1, fix_en, sl_act, sl_id_d;
  int         rate, rdy_pct, ard_pct, rv_pct, rcount;
  logic [31:0] fix_data;
  logic [7:0] sl_beat, sl_len_d;

  task automatic new_req(input logic i, input logic [31:0] a, input logic [7:0] l,
                         input logic [1:0] b);
    if (!i) begin m0_araddr = a; m0_arlen = l; m0_arburst = b; m0_arvalid = 1'b1; end
    else    begin m1_araddr = a; m1_arlen = l; m1_arburst = b; m1_arvalid = 1'b1; end
  endtask

  task automatic step();
    r_t rb;
    @(posedge clock); #1;
    if (ar_hs0) m0_arvalid = 1'b0;
    if (ar_hs1) m1_arvalid = 1'b0;
    if (!m0_arvalid && en0 && $urandom_range(0, 99) < rate)
      new_req(1'b0, $urandom, 8'($urandom_range(0, 3)), 2'($urandom_range(0, 2)));
    if (!m1_arvalid && en1 && $urandom_range(0, 99) < rate)
      new_req(1'b1, $urandom, 8'($urandom_range(0, 3)), 2'($urandom_range(0, 2)));
    m0_rready = ($urandom_range(0, 99) < rdy_pct);
    m1_rready = ($urandom_range(0, 99) < rdy_pct);
    s_arready = ($urandom_range(0, 99) < ard_pct);
    if (r_hs) begin
      rcount++;
      s_rvalid = 1'b0; s_rlast = 1'b0;
      if (sl_beat == sl_len_d) sl_act = 1'b0;
      else sl_beat++;
    end
    if (sl_start) begin
      sl_act = 1'b1; sl_beat = 8'd0; sl_len_d = sl_start_len; sl_id_d = sl_start_id;
    end
    if (sl_act && !s_rvalid && $urandom_range(0, 99) < rv_pct) begin
      s_rdata  = fix_en ? fix_data : $urandom;
      s_rresp  = fix_en ? 2'b00 : 2'($urandom_range(0, 3));
      s_rlast  = (sl_beat == sl_len_d);
      s_rvalid = 1'b1;
      rb.data = s_rdata; rb.resp = s_rresp; rb.last = s_rlast;
      if (sl_id_d) exp_r1.push_back(rb);
      else         exp_r0.push_back(rb);
    end
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    m0_arvalid = 1'b0; m1_arvalid = 1'b0;
    s_rvalid = 1'b0; s_rlast = 1'b0; sl_act = 1'b0; s_arready = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic drain();
    logic done;
    en0 = 1'b0; en1 = 1'b0;
    if (rdy_pct < 50) rdy_pct = 50;
    if (ard_pct < 50) ard_pct = 50;
    if (rv_pct < 50) rv_pct = 50;
    done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      step();
      done = !m0_arvalid && !m1_arvalid && !sl_act && mdl_idle &&
             exp_ar.size() == 0 && exp_r0.size() == 0 && exp_r1.size() == 0;
    end
    chk("drained", 64'(done), 64'd1);
  endtask

  initial begin
    reset = 1'b1;
    m0_arvalid = 1'b0; m0_araddr = '0; m0_arlen = '0; m0_arburst = '0; m0_rready = 1'b0;
    m1_arvalid = 1'b0; m1_araddr = '0; m1_arlen = '0; m1_arburst = '0; m1_rready = 1'b0;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0;
    en0 = 1'b0; en1 = 1'b0; fix_en = 1'b0; fix_data = '0;
    sl_act = 1'b0; sl_id_d = 1'b0; sl_beat = '0; sl_len_d = '0;
    rate = 0; rdy_pct = 100; ard_pct = 100; rv_pct = 100; rcount = 0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // single read from fetch, fixed instruction word
    fix_en = 1'b1; fix_data = 32'h0000_0413;
    new_req(1'b0, 32'h8000_0000, 8'd0, 2'b01);
    drain();
    fix_en = 1'b0;

    // 4-beat INCR burst from load path, fetch request arrives mid-burst
    new_req(1'b1, 32'h8000_0100, 8'd3, 2'b01);
    rv_pct = 60;
    repeat (4) step();
    new_req(1'b0, 32'h8000_0010, 8'd0, 2'b01);
    drain();

    // both requesters saturate: grants must alternate
    en0 = 1'b1; en1 = 1'b1; rate = 100; rdy_pct = 100; ard_pct = 100; rv_pct = 100;
    repeat (60) step();
    drain();

    // address stall for 5 cycles, then throttled read-data acceptance
    new_req(1'b1, 32'h8000_0200, 8'd3, 2'b01);
    ard_pct = 0;
    repeat (5) step();
    ard_pct = 100; rdy_pct = 40; rv_pct = 100;
    repeat (3) step();
    drain();

    // randomized mixed traffic with backpressure on every channel
    en0 = 1'b1; en1 = 1'b1; rate = 30; rdy_pct = 70; ard_pct = 60; rv_pct = 70;
    repeat (1500) step();
    drain();

    // reset in the middle of an 8-beat burst, then a fresh load request
    rdy_pct = 100; ard_pct = 100; rv_pct = 100; rcount = 0;
    new_req(1'b0, 32'h8000_0300, 8'd7, 2'b01);
    for (int k = 0; k < 100 && rcount < 3; k++) step();
    chk("beats_before_reset", 64'(rcount), 64'd3);
    reset_pulse();
    new_req(1'b1, 32'h8000_0400, 8'd1, 2'b01);
    drain();

    chk("fp_grant_count_ok", 64'(fp_grants >= 10), 64'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Two-requester AXI4 read-channel arbiter between the CPU's fetch path (m0, IFU) and load path (m1, LSU) and the single AXI4 master read port (s_*) towards memory/MMIO.
- Grants one requester at a time and holds the grant for the whole transaction, through the rlast handshake.
- Arbitration is round-robin, with an optional fixed priority for m0.
- The write channels do not pass through this block.

Parameters:
- FIX_PRIO, 0, when 1 m0 always wins simultaneous requests; when 0 round-robin.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clock  input  1  system clock
- reset  input  1  reset
- m0_arvalid / m1_arvalid  input  1  requester read-address valid
- m0_arready / m1_arready  output  1  requester read-address ready
- m0_araddr / m1_araddr  input  ADDR_W  requester read address
- m0_arlen / m1_arlen  input  8  burst length minus 1
- m0_arburst / m1_arburst  input  2  burst type
- m0_rvalid / m1_rvalid  output  1  read data valid to requester
- m0_rready / m1_rready  input  1  requester read-data ready
- m0_rdata / m1_rdata  output  DATA_W  read data to requester
- m0_rresp / m1_rresp  output  2  read response to requester
- m0_rlast / m1_rlast  output  1  last beat to requester
- s_arvalid  output  1  downstream read-address valid
- s_arready  input  1  downstream read-address ready
- s_araddr  output  ADDR_W  downstream read address
- s_arlen  output  8  downstream burst length
- s_arburst  output  2  downstream burst type
- s_arid  output  4  downstream ID, equal to the owner index (0 or 1)
- s_arsize  output  3  constant 3'b010
- s_rvalid  input  1  downstream read data valid
- s_rready  output  1  downstream read-data ready
- s_rdata  input  DATA_W  downstream read data
- s_rresp  input  2  downstream read response
- s_rlast  input  1  downstream last beat

Behaviour:
- One clock; reset is synchronous and active-high.
- Registers: state {IDLE, ADDR, DATA}, owner (1 bit), last_owner (1 bit).
- Reset values: state=IDLE, owner=0, last_owner=1, so m0 wins the first tie.
- All handshake outputs are combinational from state and owner. In IDLE, or after reset, every valid and ready output is 0.
- IDLE state:
  - If exactly one of m0_arvalid / m1_arvalid is high, that requester becomes owner.
  - If both are high: with FIX_PRIO=1 owner=0; with FIX_PRIO=0 owner=~last_owner.
  - Next state is ADDR.
  - No requester arready is asserted in IDLE.
  - Grant latency: a request first seen at edge N gives s_arvalid=1 in cycle N+1.
- ADDR state:
  - s_arvalid = owner's arvalid.
  - s_araddr, s_arlen, s_arburst are muxed from the owner, unmodified; s_arid = {3'b0, owner}.
  - Owner's arready = s_arready; the non-owner's arready = 0.
  - On s_arvalid & s_arready, next state is DATA.
  - If the owner drops arvalid (protocol violation), stay in ADDR with s_arvalid=0.
- DATA state:
  - Owner's rvalid = s_rvalid, and s_rready = owner's rready.
  - Owner receives s_rdata, s_rresp, s_rlast; the non-owner sees rvalid=0 and rlast=0 (its rdata may carry s_rdata).
  - Beats without s_rlast keep the state in DATA; the number of beats is not counted internally.
  - On s_rvalid & s_rready & s_rlast: next state IDLE, last_owner <= owner.
- Turnaround: at least one IDLE cycle between the rlast handshake and the next s_arvalid.
- Fairness: with FIX_PRIO=0, two continuously requesting masters alternate grants strictly.
- Non-owner requests are held pending, never dropped; the non-owner's arvalid has no effect outside IDLE.
- Reset mid-operation: at the next edge state=IDLE and all outputs deassert. No pending transaction is replayed; the downstream slave is reset on the same edge.
- Simultaneous events: a request arriving during the cycle of the rlast handshake is evaluated in the following IDLE cycle.

Test Plan:
- Single read: m0 issues araddr=0x80000000, arlen=0 → s_arvalid high 1 cycle later with s_arid=0; slave returns rdata=0x00000413 with rlast → m0_rvalid=1, m0_rdata=0x00000413, m1_rvalid=0; then IDLE.
- Burst: m1 issues araddr=0x80000100, arlen=3, arburst=INCR → exactly 4 beats forwarded to m1; grant held until the 4th beat (rlast); m0 request raised mid-burst is granted only after that.
- Tie, round-robin: both request continuously from reset, FIX_PRIO=0 → grant order m0, m1, m0, m1; s_arid matches each time.
- Tie, fixed priority: FIX_PRIO=1, both request continuously → m0 is granted every time and m1 never, while m0 keeps requesting.
- Backpressure: s_arready low 5 cycles, then owner rready low on beat 2 → no beat lost or duplicated, arready/rvalid mirrored only to the owner.
- Reset during DATA of an arlen=7 burst after beat 3 → next cycle state IDLE, all valids 0; a fresh m1 request afterwards is granted normally (last_owner=1, so on a tie m0 wins).
